// File: rtl/vx_muldiv_arb.sv
// vx_muldiv_arb: round-robin arbiter that shares one mul/div unit among NUM_REQS
// issue requesters. The winner is held in a one-entry output buffer. A credit
// counter caps outstanding divides so a serial divide backlog cannot starve
// multiplies.
module vx_muldiv_arb #(
    parameter int unsigned NUM_REQS        = 4,
    parameter int unsigned DATAW           = 128,
    parameter int unsigned MAX_DIV_PENDING = 2,
    parameter int unsigned SELW            = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
    parameter int unsigned CNTW            = $clog2(MAX_DIV_PENDING + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQS-1:0]       req_valid,
    input  logic [NUM_REQS-1:0]       req_is_div,
    input  logic [NUM_REQS*DATAW-1:0] req_data,
    output logic [NUM_REQS-1:0]       req_ready,
    output logic                      out_valid,
    output logic                      out_is_div,
    output logic [SELW-1:0]           out_sel,
    output logic [DATAW-1:0]          out_data,
    input  logic                      out_ready,
    input  logic                      div_done,
    output logic [CNTW-1:0]           div_pending
);

    localparam logic [CNTW-1:0] DIV_MAX  = CNTW'(MAX_DIV_PENDING);
    localparam logic [SELW-1:0] SEL_LAST = SELW'(NUM_REQS - 1);

    // Round-robin pointer: first index searched on the next grant.
    logic [SELW-1:0]       rr_ptr;
    logic [SELW-1:0]       rr_ptr_n;

    // Eligibility and grant.
    logic                  div_room;
    logic [NUM_REQS-1:0]   elig;
    logic                  hi_valid;
    logic [SELW-1:0]       hi_idx;
    logic [SELW-1:0]       lo_idx;
    logic                  grant_valid;
    logic [SELW-1:0]       grant_idx;
    logic                  grant_is_div;
    logic [DATAW-1:0]      grant_data;

    // Handshake qualifiers.
    logic                  load;
    logic                  accept;
    logic                  accept_div;
    logic                  done_eff;

    // Next-state values for the output buffer and divide counter.
    logic                  out_valid_n;
    logic                  out_is_div_n;
    logic [SELW-1:0]       out_sel_n;
    logic [DATAW-1:0]      out_data_n;
    logic [CNTW-1:0]       div_pending_n;

    // Divides are only eligible while a credit is free; no same-cycle bypass from div_done.
    assign div_room = (div_pending < DIV_MAX);
    assign elig     = req_valid & (~req_is_div | {NUM_REQS{div_room}});

    // The buffer can take a new request when empty or draining this cycle.
    assign load       = !out_valid || out_ready;
    assign accept     = !reset && load && grant_valid;
    assign accept_div = accept && grant_is_div;

    // A done pulse with nothing pending is dropped so the counter saturates at zero.
    assign done_eff   = div_done && (div_pending != '0);

    // Grant search: lowest eligible index at or above rr_ptr, else lowest eligible overall (wrap).
    always_comb begin
        grant_valid = 1'b0;
        hi_valid    = 1'b0;
        hi_idx      = '0;
        lo_idx      = '0;
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
            if (elig[i]) begin
                grant_valid = 1'b1;
                lo_idx      = SELW'(i);
                if (SELW'(i) >= rr_ptr) begin
                    hi_valid = 1'b1;
                    hi_idx   = SELW'(i);
                end
            end
        end
        grant_idx = hi_valid ? hi_idx : lo_idx;
    end

    // Payload and divide flag of the granted requester.
    always_comb begin
        grant_is_div = 1'b0;
        grant_data   = '0;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            if (grant_idx == SELW'(i)) begin
                grant_is_div = req_is_div[i];
                grant_data   = req_data[i*DATAW +: DATAW];
            end
        end
    end

    // One-hot accept strobe toward the requesters.
    always_comb begin
        req_ready = '0;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            req_ready[i] = accept && (grant_idx == SELW'(i));
        end
    end

    // Next-state for buffer, pointer and divide credit counter.
    always_comb begin
        out_valid_n   = out_valid;
        out_is_div_n  = out_is_div;
        out_sel_n     = out_sel;
        out_data_n    = out_data;
        rr_ptr_n      = rr_ptr;
        div_pending_n = div_pending;

        if (accept) begin
            out_valid_n  = 1'b1;
            out_is_div_n = grant_is_div;
            out_sel_n    = grant_idx;
            out_data_n   = grant_data;
            rr_ptr_n     = (grant_idx == SEL_LAST) ? '0 : grant_idx + SELW'(1);
        end else if (out_valid && out_ready) begin
            out_valid_n  = 1'b0;
        end

        if (accept_div && !done_eff) begin
            div_pending_n = div_pending + CNTW'(1);
        end else if (!accept_div && done_eff) begin
            div_pending_n = div_pending - CNTW'(1);
        end
    end

    // State registers with synchronous reset; reset drops any buffered request.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_is_div  <= 1'b0;
            out_sel     <= '0;
            out_data    <= '0;
            rr_ptr      <= '0;
            div_pending <= '0;
        end else begin
            out_valid   <= out_valid_n;
            out_is_div  <= out_is_div_n;
            out_sel     <= out_sel_n;
            out_data    <= out_data_n;
            rr_ptr      <= rr_ptr_n;
            div_pending <= div_pending_n;
        end
    end

    // Flag a divide completion that has no matching outstanding divide.
    always_ff @(posedge clk) begin
        if (!reset && div_done) begin
            assert (div_pending != '0)
                else $error("vx_muldiv_arb: div_done received with no divide pending");
        end
    end

endmodule

// File: doc/vx_muldiv_arb.md
# vx_muldiv_arb

Round-robin request arbiter that shares one integer mul/div unit among `NUM_REQS` issue requesters, e.g. per-warp issue slots. It sits between the issue stage and the mul/div unit's `valid_in`/`ready_in` handshake and registers the granted request in a one-entry output buffer. It also throttles divides with a credit counter, so a long-latency serial divide backlog cannot monopolise the unit.

## Interface
Parameters:
- `NUM_REQS`, 4, number of requesters; ≥1, any value (not limited to powers of two).
- `DATAW`, 128, opaque request payload width (op, uuid, wid, tmask, PC, rd, wb, operands).
- `MAX_DIV_PENDING`, 2, maximum divides accepted but not yet retired; ≥1.
- `SELW`, derived, `max(1, clog2(NUM_REQS))`.
- `CNTW`, derived, `clog2(MAX_DIV_PENDING+1)`.

Ports:
- `clk`  in  1  clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQS  per-requester request valid.
- `req_is_div`  in  NUM_REQS  request is DIV/DIVU/REM/REMU.
- `req_data`  in  NUM_REQS×DATAW  per-requester payload; requester i occupies bits [i·DATAW +: DATAW].
- `req_ready`  out  NUM_REQS  accept strobe; at most one bit set per cycle.
- `out_valid`  out  1  buffered request valid toward the mul/div unit.
- `out_is_div`  out  1  buffered request is a divide.
- `out_sel`  out  SELW  index of the requester that owns the buffered request.
- `out_data`  out  DATAW  buffered payload.
- `out_ready`  in  1  mul/div unit ready_in.
- `div_done`  in  1  one-cycle pulse per divide result leaving the unit.
- `div_pending`  out  CNTW  current outstanding-divide count.

## Operation
- Eligibility: `elig[i] = req_valid[i] && (!req_is_div[i] || div_pending < MAX_DIV_PENDING)`.
- Grant: the first eligible index at or after `rr_ptr`, searching upward and wrapping modulo `NUM_REQS`. The grant is combinational; no grant is made if no requester is eligible.
- Buffer load enable: `load = !out_valid || out_ready`.
- `req_ready[g] = load && grant_valid`, where g is the granted index; all other bits are 0. `req_ready` is forced to 0 while `reset` is high.
- On `req_valid[g] && req_ready[g]` (accept):
  - `out_valid` ← 1.
  - `out_data` ← `req_data[g]`, `out_is_div` ← `req_is_div[g]`, `out_sel` ← g.
  - `rr_ptr` ← (g+1) mod `NUM_REQS`.
- On `out_valid && out_ready` with no accept in the same cycle: `out_valid` ← 0; the data fields hold their values.
- `rr_ptr` is unchanged in cycles with no accept.
- Divide counter, next value:
  - Accept with `is_div` and no `div_done`: +1.
  - `div_done` and no divide accept: −1.
  - Both in the same cycle: unchanged.
  - `div_done` while the count is 0: ignored; the counter saturates at 0 and a simulation assertion fires.
- There is no same-cycle credit bypass. At count == MAX, a divide is ineligible even if `div_done` is high that cycle.
- Multiplies are never throttled and may bypass a blocked divide from another requester.
- Requesters must hold `req_valid` and `req_data` stable until accepted. The arbiter does not depend on this for correctness.

## Timing
- Latency: a request accepted in cycle N appears on `out_valid` in cycle N+1.
- Throughput: one request per cycle while `out_ready` is held high.
- Back-pressure: when `out_valid=1` and `out_ready=0`, `load=0`, so all `req_ready` bits are 0. `out_*` hold stable until the transfer completes.
- Simultaneous drain and accept (`out_ready=1` with a new grant): the buffer reloads in the same edge and `out_valid` stays 1.
- Reset values: `out_valid`=0, `out_is_div`=0, `out_sel`=0, `out_data`=0, `div_pending`=0, `rr_ptr`=0.
- Reset mid-operation: a buffered request is dropped and the count is cleared. The surrounding unit is reset on the same `reset`.
- Fairness: each continuously eligible requester is granted within `NUM_REQS` accepts.

## Test plan
- Round-robin: `NUM_REQS`=4, all `req_valid`=1 multiplies, `out_ready`=1 → `out_sel` sequence 0,1,2,3,0 starting the cycle after reset release, one request per cycle.
- Back-pressure: `out_ready`=0 for 3 cycles with the buffer full → `req_ready`=0000, and `out_data`/`out_sel` stable. Releasing `out_ready` → the next grant loads in the same cycle and `out_valid` stays 1.
- Divide throttle: `MAX_DIV_PENDING`=2, requesters 0–2 issue divides and requester 3 a multiply, `div_done`=0 → divides from 0 and 1 accepted, requester 3 granted next, requester 2 blocked. `div_pending`=2. One `div_done` pulse → `div_pending`=1, then requester 2 is granted the following cycle.
- Simultaneous events: a divide accept and `div_done` in the same cycle with the count at 1 → the count stays 1. `div_done` with the count at 0 → the count stays 0 and the assertion flags it.
- Non-power-of-two: `NUM_REQS`=3, only requesters 2 and 0 valid → `out_sel` alternates 2,0,2 and `rr_ptr` wraps 2→0 correctly.
- Reset mid-stream: `reset` asserted while `out_valid`=1 and `div_pending`=2 → the next cycle shows `out_valid`=0, `div_pending`=0, `req_ready`=0. After release, the first grant goes to the lowest valid index.
